// File: rtl/dht_filter_pkg.sv
// Shared types, limits and tenths-format helpers for the DHT11 reading filter.
package dht_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_EMIT   = 3'd4
    } filter_state_t;

    localparam int TENTHS_W   = 10;
    localparam int TEMP_MAX   = 50;
    localparam int HUM_MIN    = 20;
    localparam int HUM_MAX    = 90;
    localparam int DIV_CYCLES = 10;

    // Only meaningful for in-range readings; out-of-range ones are rejected before use.
    function automatic logic [TENTHS_W-1:0] to_tenths(input logic [7:0] int_part,
                                                      input logic [7:0] dec_part);
        return TENTHS_W'(({4'd0, int_part} * 12'd10) + {4'd0, dec_part});
    endfunction

    function automatic logic [TENTHS_W-1:0] abs_diff(input logic [TENTHS_W-1:0] a,
                                                     input logic [TENTHS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/div10_seq.sv
// Restoring divide of a tenths value by 10, one dividend bit per cycle.
// The start cycle already retires the MSB, so done arrives on the 10th cycle of the divide phase.
module div10_seq
    import dht_filter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [TENTHS_W-1:0] i_dividend,
    output logic                o_done,
    output logic [7:0]          o_quotient,
    output logic [3:0]          o_remainder
);

    logic [TENTHS_W-1:0] r_dvd;
    logic [7:0]          r_quo;
    logic [3:0]          r_rem;
    logic [3:0]          r_cnt;
    logic                r_done;

    logic [TENTHS_W-1:0] w_dvd_in;
    logic [6:0]          w_quo_in;
    logic [3:0]          w_rem_in;
    logic [4:0]          w_trial;
    logic                w_fits;
    logic [3:0]          w_rem_next;
    logic [7:0]          w_quo_next;
    logic [TENTHS_W-1:0] w_dvd_next;

    // One restoring step, seeded from the new operand on start.
    always_comb begin
        if (i_start) begin
            w_dvd_in = i_dividend;
            w_quo_in = 7'd0;
            w_rem_in = 4'd0;
        end else begin
            w_dvd_in = r_dvd;
            w_quo_in = r_quo[6:0];
            w_rem_in = r_rem;
        end
        w_trial = {w_rem_in, w_dvd_in[TENTHS_W-1]};
        w_fits  = (w_trial >= 5'd10);
        if (w_fits) begin
            w_rem_next = 4'(w_trial - 5'd10);
        end else begin
            w_rem_next = w_trial[3:0];
        end
        w_quo_next = {w_quo_in, w_fits};
        w_dvd_next = {w_dvd_in[TENTHS_W-2:0], 1'b0};
    end

    // Iteration counter, partial remainder/quotient and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd  <= {TENTHS_W{1'b0}};
            r_quo  <= 8'd0;
            r_rem  <= 4'd0;
            r_cnt  <= 4'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_dvd <= w_dvd_next;
                r_quo <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= 4'(DIV_CYCLES - 1);
            end else if (r_cnt != 4'd0) begin
                r_dvd  <= w_dvd_next;
                r_quo  <= w_quo_next;
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt - 4'd1;
                r_done <= (r_cnt == 4'd1);
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/dht_reading_filter.sv
// Validates DHT11 readings, keeps a ring-buffer moving average and flags stale data.
module dht_reading_filter
    import dht_filter_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int STALE_SEC   = 5,
    parameter int DEPTH_LOG2  = 2,
    parameter int MAX_STEP_T  = 50,
    parameter int MAX_STEP_H  = 100,
    parameter int REJECT_LOCK = 3
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_in_valid,
    input  logic       i_in_error,
    input  logic [7:0] i_hum_int,
    input  logic [7:0] i_hum_dec,
    input  logic [7:0] i_temp_int,
    input  logic [7:0] i_temp_dec,
    output logic       o_out_valid,
    output logic [7:0] o_out_hum_int,
    output logic [7:0] o_out_hum_dec,
    output logic [7:0] o_out_temp_int,
    output logic [7:0] o_out_temp_dec,
    output logic       o_rejected,
    output logic [7:0] o_reject_cnt,
    output logic       o_stale,
    output logic       o_busy
);

    localparam int          DEPTH        = 1 << DEPTH_LOG2;
    localparam int          SUM_W        = TENTHS_W + DEPTH_LOG2;
    localparam int unsigned STALE_CYCLES = STALE_SEC * CLK_HZ;
    localparam int          STALE_W      = $clog2(STALE_CYCLES + 1);

    filter_state_t       r_state;
    logic [7:0]          r_hum_int, r_hum_dec, r_temp_int, r_temp_dec;
    logic                r_primed, r_reprime;
    logic [7:0]          r_consec;
    logic [7:0]          r_reject_cnt;
    logic                r_rejected, r_out_valid, r_stale, r_busy;
    logic [7:0]          r_out_hum_int, r_out_hum_dec, r_out_temp_int, r_out_temp_dec;
    logic [TENTHS_W-1:0] r_buf_t [DEPTH];
    logic [TENTHS_W-1:0] r_buf_h [DEPTH];
    logic [SUM_W-1:0]    r_sum_t, r_sum_h;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [STALE_W-1:0]  r_stale_cnt;

    logic [TENTHS_W-1:0] w_v_t, w_v_h, w_avg_t, w_avg_h;
    logic                w_range_bad, w_step_bad, w_lock_hit, w_prime, w_stale_hit;
    logic [SUM_W-1:0]    w_sum_next_t, w_sum_next_h;
    logic                w_div_start, w_done_t, w_done_h;
    logic [7:0]          w_quo_t, w_quo_h;
    logic [3:0]          w_rem_t, w_rem_h;

    // Reading validation and next ring sums.
    always_comb begin
        w_v_t   = to_tenths(r_temp_int, r_temp_dec);
        w_v_h   = to_tenths(r_hum_int, r_hum_dec);
        w_avg_t = r_sum_t[SUM_W-1:DEPTH_LOG2];
        w_avg_h = r_sum_h[SUM_W-1:DEPTH_LOG2];
        w_range_bad = (r_temp_dec > 8'd9) || (r_hum_dec > 8'd9) ||
                      (r_temp_int > 8'(TEMP_MAX)) ||
                      (r_hum_int < 8'(HUM_MIN)) || (r_hum_int > 8'(HUM_MAX));
        w_step_bad  = r_primed &&
                      ((abs_diff(w_v_t, w_avg_t) > TENTHS_W'(MAX_STEP_T)) ||
                       (abs_diff(w_v_h, w_avg_h) > TENTHS_W'(MAX_STEP_H)));
        w_lock_hit  = (r_consec == 8'(REJECT_LOCK - 1));
        w_prime     = !r_primed || r_reprime;
        if (w_prime) begin
            w_sum_next_t = {w_v_t, {DEPTH_LOG2{1'b0}}};
            w_sum_next_h = {w_v_h, {DEPTH_LOG2{1'b0}}};
        end else begin
            w_sum_next_t = r_sum_t - {{DEPTH_LOG2{1'b0}}, r_buf_t[r_wptr]} + {{DEPTH_LOG2{1'b0}}, w_v_t};
            w_sum_next_h = r_sum_h - {{DEPTH_LOG2{1'b0}}, r_buf_h[r_wptr]} + {{DEPTH_LOG2{1'b0}}, w_v_h};
        end
        w_div_start = (r_state == ST_UPDATE);
        w_stale_hit = (r_state != ST_UPDATE) && (r_stale_cnt == STALE_W'(STALE_CYCLES - 1));
    end

    // The dividers load the post-update average directly so DIVIDE stays at 10 cycles.
    div10_seq u_div_t (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_dividend  (w_sum_next_t[SUM_W-1:DEPTH_LOG2]),
        .o_done      (w_done_t),
        .o_quotient  (w_quo_t),
        .o_remainder (w_rem_t)
    );

    div10_seq u_div_h (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_dividend  (w_sum_next_h[SUM_W-1:DEPTH_LOG2]),
        .o_done      (w_done_h),
        .o_quotient  (w_quo_h),
        .o_remainder (w_rem_h)
    );

    // Cycles since the last accepted reading; holds once the stale point is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stale_cnt <= {STALE_W{1'b0}};
        end else if (r_state == ST_UPDATE) begin
            r_stale_cnt <= {STALE_W{1'b0}};
        end else if (r_stale_cnt != STALE_W'(STALE_CYCLES)) begin
            r_stale_cnt <= r_stale_cnt + STALE_W'(1);
        end else begin
            r_stale_cnt <= r_stale_cnt;
        end
    end

    // Ring buffer and running sums.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_t[i] <= {TENTHS_W{1'b0}};
                r_buf_h[i] <= {TENTHS_W{1'b0}};
            end
            r_sum_t <= {SUM_W{1'b0}};
            r_sum_h <= {SUM_W{1'b0}};
            r_wptr  <= {DEPTH_LOG2{1'b0}};
        end else if (r_state == ST_UPDATE) begin
            r_sum_t <= w_sum_next_t;
            r_sum_h <= w_sum_next_h;
            if (w_prime) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_buf_t[i] <= w_v_t;
                    r_buf_h[i] <= w_v_h;
                end
            end else begin
                r_buf_t[r_wptr] <= w_v_t;
                r_buf_h[r_wptr] <= w_v_h;
                r_wptr          <= r_wptr + DEPTH_LOG2'(1);
            end
        end else begin
            r_wptr <= r_wptr;
        end
    end

    // Control FSM with registered status and output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_hum_int      <= 8'd0;
            r_hum_dec      <= 8'd0;
            r_temp_int     <= 8'd0;
            r_temp_dec     <= 8'd0;
            r_primed       <= 1'b0;
            r_reprime      <= 1'b0;
            r_consec       <= 8'd0;
            r_reject_cnt   <= 8'd0;
            r_rejected     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_stale        <= 1'b0;
            r_busy         <= 1'b0;
            r_out_temp_int <= 8'd25;
            r_out_temp_dec <= 8'd0;
            r_out_hum_int  <= 8'd50;
            r_out_hum_dec  <= 8'd0;
        end else begin
            r_rejected  <= 1'b0;
            r_out_valid <= 1'b0;
            if (w_stale_hit) begin
                r_stale  <= 1'b1;
                r_primed <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid && !i_in_error) begin
                        r_hum_int  <= i_hum_int;
                        r_hum_dec  <= i_hum_dec;
                        r_temp_int <= i_temp_int;
                        r_temp_dec <= i_temp_dec;
                        r_reprime  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_range_bad) begin
                        r_rejected   <= 1'b1;
                        r_reject_cnt <= (r_reject_cnt == 8'hFF) ? 8'hFF : r_reject_cnt + 8'd1;
                        r_consec     <= 8'd0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_step_bad) begin
                        r_reject_cnt <= (r_reject_cnt == 8'hFF) ? 8'hFF : r_reject_cnt + 8'd1;
                        if (w_lock_hit) begin
                            r_reprime <= 1'b1;
                            r_state   <= ST_UPDATE;
                        end else begin
                            r_rejected <= 1'b1;
                            r_consec   <= r_consec + 8'd1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_primed  <= 1'b1;
                    r_reprime <= 1'b0;
                    r_stale   <= 1'b0;
                    r_consec  <= 8'd0;
                    r_state   <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (w_done_t && w_done_h) begin
                        r_out_temp_int <= w_quo_t;
                        r_out_temp_dec <= {4'd0, w_rem_t};
                        r_out_hum_int  <= w_quo_h;
                        r_out_hum_dec  <= {4'd0, w_rem_h};
                        r_out_valid    <= 1'b1;
                        r_state        <= ST_EMIT;
                    end else begin
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_EMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_out_hum_int  = r_out_hum_int;
    assign o_out_hum_dec  = r_out_hum_dec;
    assign o_out_temp_int = r_out_temp_int;
    assign o_out_temp_dec = r_out_temp_dec;
    assign o_rejected     = r_rejected;
    assign o_reject_cnt   = r_reject_cnt;
    assign o_stale        = r_stale;
    assign o_busy         = r_busy;

endmodule
